// File: rtl/pipelined_chunk_adder_pkg.sv
// Shared constants and helpers for the pipelined chunk adder.
//   DEFAULT_WIDTH / DEFAULT_CHUNK : default operand width and slice width.
//   calc_nstg()                   : number of pipeline stages (WIDTH / CHUNK).
//   cfg_ok()                      : legality of a WIDTH/CHUNK pair, checked at elaboration.
package pipelined_chunk_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;
    localparam int unsigned DEFAULT_CHUNK = 16;

    // CHUNK must be nonzero and divide WIDTH exactly.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    // Guarded against CHUNK=0 so an illegal configuration still elaborates far enough
    // to reach the explicit configuration check in the top module.
    function automatic int unsigned calc_nstg(input int unsigned width, input int unsigned chunk);
        if (!cfg_ok(width, chunk)) begin
            return 1;
        end
        return width / chunk;
    endfunction

endpackage

// File: rtl/pipelined_chunk_adder_if.sv
// Operand/result handshake bundle for the pipelined chunk adder.
//   in_valid/in_ready   : operand beat handshake (a, b, cin[, sub]).
//   out_valid/out_ready : result beat handshake (sum, cout[, ovf]).
//   master modport      : producer of operands / consumer of results (testbench side).
//   slave modport       : the adder itself.
// Optional macro PIPELINED_CHUNK_ADDER_SUB_EN adds the sub input and ovf output.
interface pipelined_chunk_adder_if
    import pipelined_chunk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
    logic             sub;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif

endinterface

// File: rtl/pipelined_chunk_adder_chunk_stage.sv
// adder_chunk_stage: one registered CHUNK-bit add with carry in/out.
//   clk, rst_n : clock, asynchronous active-low reset (clears sum and carry).
//   en         : load enable (pipeline advance).
//   a, b, ci   : slice operands and carry in.
//   s, co      : registered slice sum and carry out.
module adder_chunk_stage
    import pipelined_chunk_adder_pkg::*;
#(
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0]   add_d;
    logic [CHUNK-1:0] s_q;
    logic             co_q;

    assign add_d = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= '0;
            co_q <= 1'b0;
        end else if (en) begin
            s_q  <= add_d[CHUNK-1:0];
            co_q <= add_d[CHUNK];
        end
    end

    assign s  = s_q;
    assign co = co_q;

endmodule

// File: rtl/pipelined_chunk_adder.sv
// pipelined_chunk_adder: WIDTH-bit adder split into NSTG = WIDTH/CHUNK pipeline stages.
// Stage k adds slice k of the operands plus the registered carry of stage k-1, so the
// critical path is one CHUNK-bit add. Upper operand slices are delayed through skew
// registers until their stage; finished lower sum slices are delayed through deskew
// registers so that all slices of one beat leave together. Latency is NSTG cycles.
//   clk, rst_n : clock, asynchronous active-low reset (discards all in-flight beats).
//   bus        : slave side of pipelined_chunk_adder_if (operand and result handshakes).
// The whole pipe advances together when the output slot is free or being taken
// (adv = out_ready | ~out_valid); in_ready equals adv.
// Optional macro PIPELINED_CHUNK_ADDER_SUB_EN: sub=1 computes a + ~b + 1 (cin ignored,
// cout=1 means no borrow) and ovf flags signed overflow of the result.
module pipelined_chunk_adder
    import pipelined_chunk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_chunk_adder_if.slave bus
);

    localparam int unsigned NSTG = calc_nstg(WIDTH, CHUNK);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
        $fatal(1, "pipelined_chunk_adder: WIDTH must be a nonzero multiple of CHUNK");
    end

    logic             adv;
    logic [NSTG-1:0]  vld_q;
    logic [NSTG-1:0]  vld_d;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [NSTG-1:0]  carry;
    logic [NSTG-1:0]  ci_stg;
    logic [CHUNK-1:0] a_stg [NSTG];
    logic [CHUNK-1:0] b_stg [NSTG];
    logic [CHUNK-1:0] s_stg [NSTG];
    logic [WIDTH-1:0] sum_w;

    assign adv          = bus.out_ready | ~vld_q[NSTG-1];
    assign bus.in_ready = adv;

`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
    // Subtraction is folded in at the input: invert B once, force carry-in to 1.
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.cin;
`endif

    // Valid bits shift in lock-step with the data; bubbles only leave at the output.
    always_comb begin
        vld_d = vld_q;
        if (adv) begin
            vld_d[0] = bus.in_valid;
            for (int k = 1; k < NSTG; k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    for (genvar j = 0; j < NSTG; j++) begin : g_slice
        if (j == 0) begin : g_head
            assign a_stg[j]  = bus.a[CHUNK-1:0];
            assign b_stg[j]  = b_eff[CHUNK-1:0];
            assign ci_stg[j] = cin_eff;
        end else begin : g_skew
            // j-deep delay so slice j reaches stage j together with carry[j-1].
            logic [CHUNK-1:0] a_sk_q [j];
            logic [CHUNK-1:0] b_sk_q [j];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int m = 0; m < j; m++) begin
                        a_sk_q[m] <= '0;
                        b_sk_q[m] <= '0;
                    end
                end else if (adv) begin
                    a_sk_q[0] <= bus.a[j*CHUNK +: CHUNK];
                    b_sk_q[0] <= b_eff[j*CHUNK +: CHUNK];
                    for (int m = 1; m < j; m++) begin
                        a_sk_q[m] <= a_sk_q[m-1];
                        b_sk_q[m] <= b_sk_q[m-1];
                    end
                end
            end

            assign a_stg[j]  = a_sk_q[j-1];
            assign b_stg[j]  = b_sk_q[j-1];
            assign ci_stg[j] = carry[j-1];
        end

        adder_chunk_stage #(
            .CHUNK(CHUNK)
        ) u_stage (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (adv),
            .a    (a_stg[j]),
            .b    (b_stg[j]),
            .ci   (ci_stg[j]),
            .s    (s_stg[j]),
            .co   (carry[j])
        );

        if (j == NSTG - 1) begin : g_tail
            assign sum_w[j*CHUNK +: CHUNK] = s_stg[j];
        end else begin : g_deskew
            // Hold finished slice j until the beat's last slice completes.
            localparam int unsigned Depth = NSTG - 1 - j;
            logic [CHUNK-1:0] d_q [Depth];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int m = 0; m < Depth; m++) begin
                        d_q[m] <= '0;
                    end
                end else if (adv) begin
                    d_q[0] <= s_stg[j];
                    for (int m = 1; m < Depth; m++) begin
                        d_q[m] <= d_q[m-1];
                    end
                end
            end

            assign sum_w[j*CHUNK +: CHUNK] = d_q[Depth-1];
        end
    end

    assign bus.out_valid = vld_q[NSTG-1];
    assign bus.sum       = sum_w;
    assign bus.cout      = carry[NSTG-1];

`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
    // Carry into the MSB is a^b^s at that bit; overflow = carry_in_msb ^ carry_out.
    // Only a^b of the MSB needs registering alongside the last stage.
    logic msb_x_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_x_q <= 1'b0;
        end else if (adv) begin
            msb_x_q <= a_stg[NSTG-1][CHUNK-1] ^ b_stg[NSTG-1][CHUNK-1];
        end
    end

    assign bus.ovf = msb_x_q ^ sum_w[WIDTH-1] ^ carry[NSTG-1];
`endif

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Self-checking bench for pipelined_chunk_adder (64-bit, 16-bit chunks, 4 stages).
// Expected results come from a plain-arithmetic model held in a FIFO scoreboard.
module tb_pipelined_chunk_adder;
    import pipelined_chunk_adder_pkg::*;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned CHUNK = 16;
    localparam int          NSTG  = WIDTH / CHUNK;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sub_v = 1'b0;
    logic ovf_s = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pipelined_chunk_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_chunk_adder #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Reference: full-precision add, signed overflow from a 2-bit sign-extended result.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t                    e;
        logic [WIDTH:0]          full;
        logic signed [WIDTH+1:0] sa, sb, sres;
        sa = $signed({a[WIDTH-1], a[WIDTH-1], a});
        sb = $signed({b[WIDTH-1], b[WIDTH-1], b});
        if (sub) begin
            full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            sres = sa - sb;
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            sres = sa + sb + {{(WIDTH+1){1'b0}}, cin};
        end
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = sres[WIDTH] != sres[WIDTH-1];
        return e;
    endfunction

    // Drive one cycle starting at posedge+1; sample outputs at posedge+2; end at next posedge+1.
    task automatic cyc(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic ic, input logic ordy, output logic ov,
                       output logic [WIDTH-1:0] os, output logic oc, output logic ir);
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.b         = ib;
        bus.cin       = ic;
        bus.out_ready = ordy;
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
        bus.sub = sub_v;
`endif
        #1;
        ov = bus.out_valid;
        os = bus.sum;
        oc = bus.cout;
        ir = bus.in_ready;
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
        ovf_s = bus.ovf;
`endif
        @(posedge clk);
        #1;
    endtask

    // Offer one beat into an empty pipe and wait (bounded) for its result.
    task automatic run_one(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                           input logic ic, output logic acc, output int lat,
                           output logic [WIDTH-1:0] rs, output logic rc, output logic ro);
        logic             ov, oc, ir;
        logic [WIDTH-1:0] os;
        cyc(1'b1, ia, ib, ic, 1'b1, ov, os, oc, ir);
        acc = ir;
        lat = 0;
        rs  = '0;
        rc  = 1'b0;
        ro  = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b1, ov, os, oc, ir);
            if (ov) begin
                lat = n;
                rs  = os;
                rc  = oc;
                ro  = ovf_s;
                break;
            end
        end
    endtask

    // Random operands biased towards long carry chains.
    task automatic new_beat(output logic [WIDTH-1:0] na, output logic [WIDTH-1:0] nb,
                            output logic nc);
        na = {$urandom, $urandom};
        nb = {$urandom, $urandom};
        nc = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            1: nb = ~na;
            2: begin
                na = '1;
                nb = WIDTH'($urandom_range(0, 3));
            end
            default: ;
        endcase
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
        sub_v = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (bus.sum !== '0) begin
            n_fails++;
            $display("FAIL reset_sum: got %h want 0", bus.sum);
        end
        n_checks++;
        if (bus.cout !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_cout: got %b want 0", bus.cout);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL release_out_valid: got %b want 0", bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic             acc, rc, ro;
        int               lat;
        logic [WIDTH-1:0] rs;
        run_one(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, acc, lat, rs, rc, ro);
        n_checks++;
        if (acc !== 1'b1) begin
            n_fails++;
            $display("FAIL single_accept: got %b want 1", acc);
        end
        n_checks++;
        if (lat != NSTG) begin
            n_fails++;
            $display("FAIL single_latency: got %0d want %0d", lat, NSTG);
        end
        n_checks++;
        if (rs !== 64'h0001_0000_0000_0000) begin
            n_fails++;
            $display("FAIL single_sum: got %h want 0001000000000000", rs);
        end
        n_checks++;
        if (rc !== 1'b0) begin
            n_fails++;
            $display("FAIL single_cout: got %b want 0", rc);
        end
    endtask

    task automatic test_wrap();
        logic             acc, rc, ro;
        int               lat;
        logic [WIDTH-1:0] rs;
        run_one('1, '0, 1'b1, acc, lat, rs, rc, ro);
        n_checks++;
        if (lat != NSTG || rs !== '0 || rc !== 1'b1) begin
            n_fails++;
            $display("FAIL wrap_ones: got lat=%0d sum=%h cout=%b want lat=%0d sum=0 cout=1",
                     lat, rs, rc, NSTG);
        end
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
        n_checks++;
        if (ro !== 1'b0) begin
            n_fails++;
            $display("FAIL wrap_ones_ovf: got %b want 0", ro);
        end
`endif
        run_one(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, acc, lat, rs, rc, ro);
        n_checks++;
        if (lat != NSTG || rs !== '0 || rc !== 1'b1) begin
            n_fails++;
            $display("FAIL wrap_msb: got lat=%0d sum=%h cout=%b want lat=%0d sum=0 cout=1",
                     lat, rs, rc, NSTG);
        end
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
        n_checks++;
        if (ro !== 1'b1) begin
            n_fails++;
            $display("FAIL wrap_msb_ovf: got %b want 1", ro);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int               sent = 0, got = 0, last_idx = -1;
        exp_t             e;
        logic [WIDTH-1:0] na, nb, os;
        logic             nc, iv, ov, oc, ir;
        exp_q.delete();
        new_beat(na, nb, nc);
        for (int i = 0; i < 20 + NSTG + 10 && got < 20; i++) begin
            iv = sent < 20;
            cyc(iv, na, nb, nc, 1'b1, ov, os, oc, ir);
            if (ov) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL b2b_spurious: got sum=%h want no output", os);
                end else begin
                    e = exp_q.pop_front();
                    if (os !== e.sum || oc !== e.cout || (got > 0 && i != last_idx + 1)
                        || ovf_s !== (e.ovf & sub_chk())) begin
                        n_fails++;
                        $display("FAIL b2b_beat%0d: got sum=%h cout=%b ovf=%b cyc=%0d want %h %b %b cyc=%0d",
                                 got, os, oc, ovf_s, i, e.sum, e.cout, e.ovf & sub_chk(),
                                 last_idx + 1);
                    end
                    last_idx = i;
                    got++;
                end
            end
            if (iv) begin
                n_checks++;
                if (ir !== 1'b1) begin
                    n_fails++;
                    $display("FAIL b2b_in_ready: got %b want 1", ir);
                end
                if (ir) begin
                    exp_q.push_back(model(na, nb, nc, sub_v));
                    sent++;
                    new_beat(na, nb, nc);
                end
            end
        end
        sub_v = 1'b0;
        n_checks++;
        if (got != 20) begin
            n_fails++;
            $display("FAIL b2b_count: got %0d results want 20", got);
        end
    endtask

    // 1 when the build exposes ovf, so default-build comparisons ignore the model's ovf.
    function automatic logic sub_chk();
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_backpressure();
        int               sent = 0, got = 0;
        exp_t             e;
        logic [WIDTH-1:0] na, nb, os, prev_os;
        logic             nc, iv, ordy, ov, oc, ir, prev_stall, prev_oc;
        exp_q.delete();
        prev_stall = 1'b0;
        prev_os    = '0;
        prev_oc    = 1'b0;
        new_beat(na, nb, nc);
        for (int i = 0; i < 1000 && got < 60; i++) begin
            iv   = (sent < 60) && ($urandom_range(0, 3) != 0);
            ordy = 1'($urandom_range(0, 1));
            cyc(iv, na, nb, nc, ordy, ov, os, oc, ir);
            n_checks++;
            if (ir !== (ordy | ~ov)) begin
                n_fails++;
                $display("FAIL bp_in_ready: got %b want %b (out_valid=%b out_ready=%b)",
                         ir, ordy | ~ov, ov, ordy);
            end
            if (prev_stall) begin
                n_checks++;
                if (ov !== 1'b1 || os !== prev_os || oc !== prev_oc) begin
                    n_fails++;
                    $display("FAIL bp_hold: got v=%b sum=%h cout=%b want v=1 sum=%h cout=%b",
                             ov, os, oc, prev_os, prev_oc);
                end
            end
            if (ov && ordy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL bp_spurious: got sum=%h want no output", os);
                end else begin
                    e = exp_q.pop_front();
                    if (os !== e.sum || oc !== e.cout || ovf_s !== (e.ovf & sub_chk())) begin
                        n_fails++;
                        $display("FAIL bp_beat%0d: got sum=%h cout=%b ovf=%b want %h %b %b",
                                 got, os, oc, ovf_s, e.sum, e.cout, e.ovf & sub_chk());
                    end
                    got++;
                end
            end
            if (iv && ir) begin
                exp_q.push_back(model(na, nb, nc, sub_v));
                sent++;
                new_beat(na, nb, nc);
            end
            prev_stall = ov & ~ordy;
            prev_os    = os;
            prev_oc    = oc;
        end
        sub_v = 1'b0;
        n_checks++;
        if (got != 60 || exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL bp_count: got %0d results, %0d left want 60, 0", got, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic [WIDTH-1:0] na, nb, os, rs;
        logic             nc, ov, oc, ir, acc, rc, ro;
        int               seen = 0, lat;
        exp_t             e;
        for (int i = 0; i < 3; i++) begin
            new_beat(na, nb, nc);
            cyc(1'b1, na, nb, nc, 1'b0, ov, os, oc, ir);
        end
        sub_v = 1'b0;
        cyc(1'b0, '0, '0, 1'b0, 1'b0, ov, os, oc, ir);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_prefill_valid: got %b want 1", bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_async_clear: got v=%b sum=%h cout=%b want 0 0 0",
                     bus.out_valid, bus.sum, bus.cout);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b1, ov, os, oc, ir);
            if (ov) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fails++;
            $display("FAIL mid_no_stale: got %0d outputs want 0", seen);
        end
        new_beat(na, nb, nc);
        sub_v = 1'b0;
        e = model(na, nb, nc, 1'b0);
        run_one(na, nb, nc, acc, lat, rs, rc, ro);
        n_checks++;
        if (acc !== 1'b1 || lat != NSTG || rs !== e.sum || rc !== e.cout) begin
            n_fails++;
            $display("FAIL mid_new_beat: got acc=%b lat=%0d sum=%h cout=%b want 1 %0d %h %b",
                     acc, lat, rs, rc, NSTG, e.sum, e.cout);
        end
    endtask

`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
    task automatic test_sub();
        logic             acc, rc, ro;
        int               lat;
        logic [WIDTH-1:0] rs;
        sub_v = 1'b1;
        run_one(64'd5, 64'd7, 1'b0, acc, lat, rs, rc, ro);
        n_checks++;
        if (lat != NSTG || rs !== 64'hFFFF_FFFF_FFFF_FFFE || rc !== 1'b0 || ro !== 1'b0) begin
            n_fails++;
            $display("FAIL sub_5_7: got lat=%0d sum=%h cout=%b ovf=%b want %0d fffffffffffffffe 0 0",
                     lat, rs, rc, ro, NSTG);
        end
        run_one(64'h7FFF_FFFF_FFFF_FFFF, '1, 1'b1, acc, lat, rs, rc, ro);
        n_checks++;
        if (lat != NSTG || rs !== 64'h8000_0000_0000_0000 || rc !== 1'b0 || ro !== 1'b1) begin
            n_fails++;
            $display("FAIL sub_ovf: got lat=%0d sum=%h cout=%b ovf=%b want %0d 8000000000000000 0 1",
                     lat, rs, rc, ro, NSTG);
        end
        sub_v = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
